// File: rtl/shift_right_unit_if.sv
// Operand, control and result signals of the multi-cycle right-shift unit.
interface shift_right_unit_if;
    logic [7:0] data_in;
    logic [7:0] shift_amt;
    logic [1:0] mode;
    logic       start;
    logic [7:0] data_out;
    logic       busy;
    logic       done;

    modport master (
        output data_in, shift_amt, mode, start,
        input  data_out, busy, done
    );

    modport slave (
        input  data_in, shift_amt, mode, start,
        output data_out, busy, done
    );
endinterface

// File: rtl/shift_right_unit.sv
// 8-bit right-shift unit (logical / arithmetic / rotate) stepping one bit per clock.
module shift_right_unit (
    input  logic               clk_i,
    input  logic               rst_ni,
    shift_right_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] work_q, work_d;
    logic [7:0] out_q, out_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] n_eff;
    logic [7:0] stepped;

    function automatic logic [7:0] step_right(input logic [7:0] w, input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'b01:   r = {w[7], w[7:1]};
            2'b10:   r = {w[0], w[7:1]};
            default: r = {1'b0, w[7:1]};
        endcase
        return r;
    endfunction

    // Rotation wraps modulo the width; shifts saturate at the full width.
    always_comb begin
        n_eff = 4'd0;
        if (bus.mode == 2'b10)
            n_eff = {1'b0, bus.shift_amt[2:0]};
        else if (bus.shift_amt >= 8'd8)
            n_eff = 4'd8;
        else
            n_eff = bus.shift_amt[3:0];
    end

    assign stepped = step_right(work_q, mode_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        out_d   = out_q;
        mode_d  = mode_q;
        case (state_q)
            S_SHIFT: begin
                work_d = stepped;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    out_d   = stepped;
                end
            end
            default: begin
                if (bus.start) begin
                    work_d = bus.data_in;
                    mode_d = bus.mode;
                    cnt_d  = n_eff;
                    if (n_eff == 4'd0) begin
                        state_d = S_DONE;
                        out_d   = bus.data_in;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            work_q  <= 8'h00;
            out_q   <= 8'h00;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.data_out = out_q;
    assign bus.busy     = (state_q == S_SHIFT);
    assign bus.done     = (state_q == S_DONE);

endmodule

// File: doc/shift_right_unit.md
SHIFT_RIGHT_UNIT -- requirements
Module: shift_right_unit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 IN  input  8  operand to be shifted right.
REQ-005 SHIFT  input  8  shift amount, unsigned.
REQ-006 MODE  input  2  00 logical, 01 arithmetic, 10 rotate-right, 11 treated as logical.
REQ-007 START  input  1  request; sampled on rising CLK.
REQ-008 OUTPUT  output  8  registered result of the last completed operation.
REQ-009 BUSY  output  1  high while shifting is in progress.
REQ-010 DONE  output  1  one-cycle pulse marking OUTPUT updated.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 START SHALL be accepted only in IDLE or DONE; while in SHIFT, START and all data inputs SHALL be ignored.
REQ-013 On the accepting edge (E0), the block SHALL capture IN, MODE and the effective count N into internal registers.
REQ-014 The effective count N SHALL be computed as follows:
- logical or arithmetic: N = min(SHIFT, 8).
- rotate: N = SHIFT mod 8.
REQ-015 If N=0, E0 SHALL go directly to DONE.
REQ-016 If N>0, E0 SHALL go to SHIFT with the counter loaded to N.
REQ-017 Each edge in SHIFT SHALL perform exactly one 1-bit right step on the working register and decrement the counter.
REQ-018 The per-step fill bit SHALL be:
- logical: 0 into bit 7.
- arithmetic: the captured bit 7 replicated into bit 7.
- rotate: bit 0 moved into bit 7.
REQ-019 The edge that performs the Nth step (E_N) SHALL transition SHIFT to DONE and load OUTPUT with the final working value.
REQ-020 For N=0, OUTPUT SHALL load the captured IN at E0.
REQ-021 Latency SHALL be max(N,0) edges after E0 to DONE entry, which is N+1 edges including E0; DONE SHALL be high for exactly the cycle following E_N.
REQ-022 From DONE, the next edge SHALL go to IDLE if START is low.
REQ-023 From DONE, if START is high on that edge, the block SHALL accept a new operation (back-to-back), and DONE SHALL fall.
REQ-024 BUSY SHALL be high exactly while the state is SHIFT; DONE SHALL be high exactly while the state is DONE; both SHALL never be high together.
REQ-025 OUTPUT SHALL hold its previous value throughout SHIFT and IDLE; it SHALL change only on DONE entry.
REQ-026 The N=8 saturation results SHALL be 0x00 for logical shifts and 0x00 or 0xFF (the captured sign) for arithmetic shifts.

Reset
REQ-027 While RESET is low, the block SHALL immediately force the state to IDLE and clear the counter, the working register, OUTPUT (0x00), BUSY (0) and DONE (0), regardless of CLK.
REQ-028 A reset asserted mid-operation SHALL abort the operation with no DONE pulse; the first START after RESET returns high SHALL behave per REQ-013.

Verification
REQ-029 The bench SHALL cover logical shift: IN=0xB4, SHIFT=3, MODE=00 -> BUSY for 3 cycles, then DONE pulse with OUTPUT=0x16.
REQ-030 The bench SHALL cover arithmetic shift and saturation:
- IN=0x90, SHIFT=2, MODE=01 -> OUTPUT=0xE4.
- IN=0x90, SHIFT=200, MODE=01 -> 8 BUSY cycles, OUTPUT=0xFF.
- Same with MODE=00 -> OUTPUT=0x00.
REQ-031 The bench SHALL cover rotate wrap: IN=0x81, SHIFT=9, MODE=10 -> 1 BUSY cycle, OUTPUT=0xC0; SHIFT=8 -> no BUSY, DONE next cycle, OUTPUT=0x81.
REQ-032 The bench SHALL cover zero shift: IN=0x5A, SHIFT=0 -> BUSY never high, DONE in the cycle after E0, OUTPUT=0x5A.
REQ-033 The bench SHALL cover ignored START and reset abort:
- START pulsed with IN=0xFF during SHIFT of a 0xB4/3/00 operation -> ignored, OUTPUT=0x16.
- RESET low mid-SHIFT -> OUTPUT=0x00, BUSY=0, DONE=0 immediately, no DONE pulse.
REQ-034 The bench SHALL cover back-to-back operation: START held high across the DONE cycle with new IN=0x40, SHIFT=1, MODE=00 -> second operation accepted at that edge, next DONE with OUTPUT=0x20.
